// File: rtl/uart_mux_pkg.sv
// Shared types and defaults for the serial-port router.
package uart_mux_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } mux_state_t;

    // Roughly one 10-bit character at 115200 baud from a 29.4 MHz clock.
    localparam int DEF_IDLE_CYCLES  = 2560;
    localparam int DEF_GUARD_CYCLES = 256;

    // A select value is only usable if it names an existing port.
    function automatic logic sel_valid(input int sel, input int n);
        return (sel >= 0) && (sel < n);
    endfunction

endpackage

// File: rtl/uart_port_mux_sync_bit.sv
// Multi-stage synchroniser for one asynchronous receive line; idles at mark (1).
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage sample the previous
        // stage's old value, which is what makes this a chain and not a wire.
        if (reset) stage_q <= '1;
        else       stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_port_mux.sv
// Routes the terminal core's UART to one of N_PORTS serial ports. A select
// change waits for a full idle character time, then holds every line at mark
// for a guard interval, so no character is ever truncated or spliced.
module uart_port_mux
    import uart_mux_pkg::*;
#(
    parameter int  N_PORTS      = 2,
    parameter int  RESET_SEL    = 0,
    parameter int  IDLE_CYCLES  = DEF_IDLE_CYCLES,
    parameter int  GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int  SYNC_STAGES  = 2,
    localparam int SEL_W        = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   sel_req,
    input  logic               core_tx,
    output logic               core_rx,
    input  logic [N_PORTS-1:0] port_rx,
    output logic [N_PORTS-1:0] port_tx,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               switching
);

    localparam int                IDLE_W     = $clog2(IDLE_CYCLES + 1);
    localparam int                GUARD_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_CYCLES);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_RST    = SEL_W'(RESET_SEL);

    logic [N_PORTS-1:0] rxs;

    mux_state_t         state_q,     state_d;
    logic [SEL_W-1:0]   sel_cur_q,   sel_cur_d;
    logic [SEL_W-1:0]   target_q,    target_d;
    logic [IDLE_W-1:0]  idle_q,      idle_d;
    logic [GUARD_W-1:0] guard_q,     guard_d;
    logic [N_PORTS-1:0] port_tx_q,   port_tx_d;
    logic               core_rx_q,   core_rx_d;
    logic               switching_q;
    logic               req_ok;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_sync
        sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (port_rx[i]),
            .q_o   (rxs[i])
        );
    end

    assign req_ok = sel_valid(int'(sel_req), N_PORTS);

    // Next state, select and counters.
    always_comb begin
        // NOTE: every variable gets a default here, so no path leaves one
        // unassigned and no latch is inferred.
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        target_d  = target_q;
        guard_d   = guard_q;
        idle_d    = '0;

        // Idle time on the connected pair; a 0 on either line restarts it.
        if (state_q != SWITCH && core_tx && rxs[sel_cur_q])
            idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;

        unique case (state_q)
            ACTIVE: begin
                if (req_ok && sel_req != sel_cur_q) begin
                    target_d = sel_req;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (req_ok) target_d = sel_req;
                if (sel_req == sel_cur_q) begin
                    state_d = ACTIVE;
                end else if (idle_q == IDLE_MAX) begin
                    state_d   = SWITCH;
                    sel_cur_d = target_d;
                    guard_d   = '0;
                end
            end
            SWITCH: begin
                guard_d = guard_q + 1'b1;
                if (guard_q == GUARD_LAST) state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    // Registered datapath: connect the selected pair, park the rest at mark.
    always_comb begin
        port_tx_d = '1;
        core_rx_d = 1'b1;
        if (state_q != SWITCH) begin
            port_tx_d[sel_cur_q] = core_tx;
            core_rx_d            = rxs[sel_cur_q];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACTIVE;
            sel_cur_q   <= SEL_RST;
            target_q    <= SEL_RST;
            idle_q      <= '0;
            guard_q     <= '0;
            port_tx_q   <= '1;
            core_rx_q   <= 1'b1;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_cur_q   <= sel_cur_d;
            target_q    <= target_d;
            idle_q      <= idle_d;
            guard_q     <= guard_d;
            port_tx_q   <= port_tx_d;
            core_rx_q   <= core_rx_d;
            switching_q <= (state_d != ACTIVE);
        end
    end

    assign port_tx   = port_tx_q;
    assign core_rx   = core_rx_q;
    assign sel_cur   = sel_cur_q;
    assign switching = switching_q;

endmodule

// File: tb/tb_uart_port_mux.sv
// Directed self-checking bench for uart_port_mux (3 ports, short timings).
module tb_uart_port_mux;

    localparam int N_PORTS = 3;
    localparam int SEL_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [SEL_W-1:0]   sel_req;
    logic               core_tx;
    logic               core_rx;
    logic [N_PORTS-1:0] port_rx;
    logic [N_PORTS-1:0] port_tx;
    logic [SEL_W-1:0]   sel_cur;
    logic               switching;

    int n_cmp = 0;
    int n_mis = 0;

    uart_port_mux #(
        .N_PORTS      (N_PORTS),
        .RESET_SEL    (0),
        .IDLE_CYCLES  (16),
        .GUARD_CYCLES (4),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel_req   (sel_req),
        .core_tx   (core_tx),
        .core_rx   (core_rx),
        .port_rx   (port_rx),
        .port_tx   (port_tx),
        .sel_cur   (sel_cur),
        .switching (switching)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int sw_cnt;
        logic [7:0] sw_hist;
        logic [SEL_W-1:0] sc_hist [8];

        reset   = 1'b1;
        sel_req = '0;
        core_tx = 1'b1;
        port_rx = 3'b111;
        ticks(3);
        reset = 1'b0;

        // 1. Reset values and core_tx -> port_tx latency.
        check("rst_sel_cur",   32'(sel_cur),   32'd0);
        check("rst_port_tx",   32'(port_tx),   32'h7);
        check("rst_core_rx",   32'(core_rx),   32'd1);
        check("rst_switching", 32'(switching), 32'd0);
        tick();
        core_tx = 1'b0;
        check("tx_lat_before", 32'(port_tx), 32'h7);
        tick();
        check("tx_lat_after", 32'(port_tx), 32'h6);
        core_tx = 1'b1;
        tick();
        check("tx_release", 32'(port_tx), 32'h7);

        // 2. port_rx -> core_rx takes SYNC_STAGES+1 = 3 cycles; other ports ignored.
        port_rx[0] = 1'b0;
        ticks(2);
        check("rx_lat_2", 32'(core_rx), 32'd1);
        tick();
        check("rx_lat_3", 32'(core_rx), 32'd0);
        port_rx[0] = 1'b1;
        ticks(4);
        port_rx[1] = 1'b0;
        ticks(5);
        check("rx_unsel_port", 32'(core_rx), 32'd1);
        port_rx[1] = 1'b1;

        // 3. Idle switch 0 -> 2: 1 DRAIN + 4 SWITCH cycles.
        ticks(20);
        sel_req = 2'd2;
        sw_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            sw_hist[i] = switching;
            sc_hist[i] = sel_cur;
            if (switching) sw_cnt++;
            check("sw_lines_mark", 32'(port_tx), 32'h7);
        end
        check("sw_cycles",      32'(sw_cnt),     32'd5);
        check("sw_first",       32'(sw_hist[0]), 32'd1);
        check("sw_done",        32'(sw_hist[5]), 32'd0);
        check("sw_sel_drain",   32'(sc_hist[0]), 32'd0);
        check("sw_sel_after",   32'(sc_hist[1]), 32'd2);
        core_tx = 1'b0;
        tick();
        check("sw_tx_port2", 32'(port_tx), 32'h3);
        core_tx = 1'b1;
        tick();
        check("sw_tx_idle", 32'(port_tx), 32'h7);
        port_rx[2] = 1'b0;
        ticks(3);
        check("sw_rx_port2", 32'(core_rx), 32'd0);
        port_rx[2] = 1'b1;

        // Return to port 0.
        sel_req = 2'd0;
        ticks(40);
        check("back_to_0", 32'(sel_cur), 32'd0);
        check("back_idle", 32'(switching), 32'd0);

        // 4. Mid-character protection: last core_tx low is cycle 71.
        for (int c = 0; c < 80; c++) begin
            core_tx = ((c / 8) % 2) ? 1'b1 : 1'b0;
            if (c == 10) sel_req = 2'd1;
            tick();
            check("mid_tx0", 32'(port_tx[0]), 32'(core_tx));
        end
        check("mid_sel_hold",  32'(sel_cur),   32'd0);
        check("mid_draining",  32'(switching), 32'd1);
        ticks(8);
        check("mid_sel_16idle", 32'(sel_cur), 32'd0);
        tick();
        check("mid_sel_switch", 32'(sel_cur), 32'd1);
        ticks(4);
        check("mid_active", 32'(switching), 32'd0);

        // Return to port 0.
        sel_req = 2'd0;
        ticks(40);
        check("back_to_0b", 32'(sel_cur), 32'd0);

        // 5a. Abort in DRAIN: keep the line busy, then withdraw the request.
        core_tx = 1'b0;
        sel_req = 2'd2;
        tick();
        check("abort_drain", 32'(switching), 32'd1);
        tick();
        check("abort_still", 32'(switching), 32'd1);
        sel_req = 2'd0;
        tick();
        check("abort_active", 32'(switching), 32'd0);
        check("abort_sel",    32'(sel_cur),   32'd0);
        core_tx = 1'b1;
        sw_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (switching) sw_cnt++;
        end
        check("abort_no_switch", 32'(sw_cnt),  32'd0);
        check("abort_sel_end",   32'(sel_cur), 32'd0);

        // 5b. Out-of-range select is ignored.
        sel_req = 2'd3;
        sw_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (switching) sw_cnt++;
        end
        check("inval_no_switch", 32'(sw_cnt),  32'd0);
        check("inval_sel",       32'(sel_cur), 32'd0);

        // 6. Reset during the second guard cycle of a 0 -> 1 switch.
        sel_req = 2'd1;
        ticks(3);
        check("rst6_in_switch", 32'(switching), 32'd1);
        check("rst6_sel_new",   32'(sel_cur),   32'd1);
        reset   = 1'b1;
        sel_req = 2'd0;
        core_tx = 1'b0;
        port_rx = 3'b000;
        tick();
        check("rst6_sel",       32'(sel_cur),   32'd0);
        check("rst6_switching", 32'(switching), 32'd0);
        check("rst6_port_tx",   32'(port_tx),   32'h7);
        check("rst6_core_rx",   32'(core_rx),   32'd1);
        reset   = 1'b0;
        core_tx = 1'b1;
        port_rx = 3'b111;
        tick();
        check("rst6_post_tx", 32'(port_tx), 32'h7);
        check("rst6_post_sw", 32'(switching), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
